debug_cmd_rx: RTL and testbench
===============================

# debug_cmd_rx

Receive side of the debug UART link. Deserialises 8N1 serial frames from the host with 16x oversampling, decodes ASCII hex characters (`0`-`9`, `A`-`F`, `a`-`f`) into 4-bit values, and queues them in a small FIFO for the debug logic to read. It is the inverse of the transmit path's binary-to-ASCII conversion plus UART transmitter, and sits beside that path in the debug top level.

## Interface
- `DVSR`, 326: system clocks per 16x oversampling tick. Bit period is 16*DVSR clocks. Legal range 2..65535.
- `FIFO_AW`, 2: FIFO address width; depth is 2^FIFO_AW entries.
- `clk` in 1: system clock. All logic is on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `rx` in 1: serial line, idle high, asynchronous to `clk`.
- `rd_rx` in 1: pop the FIFO head. Ignored while `rx_empty`=1.
- `r_data` out 4: FIFO head (show-ahead). Valid while `rx_empty`=0.
- `rx_empty` out 1: FIFO empty.
- `rx_full` out 1: FIFO full.
- `bad_char` out 1: one-cycle pulse when a received byte is not a hex digit.
- `frame_err` out 1: one-cycle pulse when the stop bit is sampled low.
- `overrun` out 1: one-cycle pulse when a decoded nibble is dropped because the FIFO is full.

## Operation
- **Input synchroniser:** `rx` passes through 2 flip-flops; all decisions use the synchronised value `rx_s`. Both flip-flops reset to 1.
- **Tick generator:** free-running counter 0..DVSR-1. `tick` is asserted for one clock when the count equals DVSR-1, then the counter wraps to 0.
- **FSM states:** IDLE, START, DATA, (PARITY), STOP. It uses a sample counter `s` (4 bits), a bit counter `n` (3 bits) and an 8-bit shift register `b`.
  - IDLE: when `rx_s`=0, go to START with `s`=0.
  - START: on `tick` with `s`=7, if `rx_s`=0 go to DATA with `s`=0 and `n`=0. If `rx_s`=1 the start was a glitch: return to IDLE with no error.
  - DATA: on `tick` with `s`=15, shift `rx_s` into the MSB of `b` (LSB-first line order) and clear `s`. At `n`=7 go to PARITY if configured, otherwise STOP; else increment `n`.
  - STOP: on `tick` with `s`=15, `rx_s`=1 means the byte is accepted; `rx_s`=0 pulses `frame_err` and drops the byte. Either way return to IDLE.
  - In all other cases, `tick` increments `s`.
- **Decode of an accepted byte:**
  - 0x30-0x39 → 0-9.
  - 0x41-0x46 → 10-15.
  - 0x61-0x66 → 10-15.
  - Any other byte: pulse `bad_char`, push nothing.
- **FIFO:** circular buffer with separate read and write pointers plus full/empty flags.
  - Push and pop in the same cycle: both take effect, including when the FIFO is full.
  - Push when full with no pop: `overrun` pulses and the FIFO is unchanged.
  - Pop when empty: ignored. If a push happens in the same cycle, the push still succeeds.
- **Reset mid-frame:** the FSM returns to IDLE and the FIFO is emptied. The partial frame is lost.

## Timing
- **Reset values:**
  - `r_data`=0, `rx_empty`=1, `rx_full`=0.
  - `bad_char`, `frame_err`, `overrun` = 0.
  - FSM in IDLE, all counters 0.
- **Latency:** synchroniser 2 clocks. The start edge is confirmed at about 8 ticks and data bits are sampled at mid-bit.
- **Push timing:** the push happens in the same clock as the STOP sample tick. `rx_empty` falls and `r_data` is valid on the next clock edge.
- **Status pulse timing:** `bad_char`, `frame_err` and `overrun` are registered and assert on the clock after the STOP sample tick, for exactly one cycle.
- **Pop timing:** `rd_rx` takes effect at the clock edge. The new head appears on `r_data` the following cycle.
- **Next frame:** a new start bit is accepted immediately after STOP; no idle gap is required beyond the stop-bit half period.

## Configuration
- `DEBUG_CMD_RX_PARITY_EN` defined:
  - The frame becomes 8E1 and a PARITY state follows DATA.
  - On `tick` with `s`=15, the parity bit is sampled and checked for even parity over the data plus parity bit.
  - On a mismatch, the byte is dropped and `frame_err` pulses at the STOP sample time, whatever the stop bit value.
- `DEBUG_CMD_RX_PARITY_EN` undefined: 8N1 framing, no PARITY state, no parity logic.

## Test plan
All scenarios use DVSR=4 (64 clocks per bit) and FIFO_AW=2.
- **Basic receive:** after reset, send `'A'` (0x41) 8N1. Expect `rx_empty` to fall and `r_data`=0xA. Assert `rd_rx` once; `rx_empty` returns to 1.
- **Back-to-back frames:** send `"0"`, `"9"`, `"f"`, `"F"` back-to-back. Expect the FIFO to read out 0x0, 0x9, 0xF, 0xF in order. `rx_full`=1 after the 4th character.
- **Overrun:** with the FIFO full, send `"3"`. Expect one `overrun` pulse and the head still 0x0. In another run, send a character with `rd_rx` held in the stop-sample cycle: no `overrun`, and the last entry is 0x3.
- **Bad character:** send `'G'` (0x47). Expect one `bad_char` pulse and `rx_empty` staying 1.
- **Framing errors:** send 0x35 with the stop bit driven low. Expect one `frame_err` pulse and nothing pushed. Send a 20-clock low glitch: no pulse, FSM back in IDLE.
- **Reset mid-frame:** assert `reset` during bit 4 of a frame. Expect all outputs at their reset values. A following clean `'7'` yields `r_data`=0x7.

Source files
------------

// File: rtl/debug_cmd_rx.sv
// Debug link receiver: 16x-oversampled 8N1 UART, ASCII hex decode, small show-ahead nibble FIFO.
// Define DEBUG_CMD_RX_PARITY_EN for 8E1 framing with an even-parity check before the stop bit.
module debug_cmd_rx #(
  parameter int unsigned DVSR    = 326,
  parameter int unsigned FIFO_AW = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       rd_rx,
  output logic [3:0] r_data,
  output logic       rx_empty,
  output logic       rx_full,
  output logic       bad_char,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned Depth   = 2 ** FIFO_AW;
  localparam logic [15:0] TickMax = 16'(DVSR - 1);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StStart  = 3'd1;
  localparam logic [2:0] StData   = 3'd2;
  localparam logic [2:0] StStop   = 3'd3;
`ifdef DEBUG_CMD_RX_PARITY_EN
  localparam logic [2:0] StParity = 3'd4;
`endif

  // ---------------------------------------------------------------------------
  // Input synchroniser (idles high so reset does not look like a start bit)
  // ---------------------------------------------------------------------------
  logic rx_meta_q;
  logic rx_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s      <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s      <= rx_meta_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Oversampling tick generator
  // ---------------------------------------------------------------------------
  logic [15:0] tick_cnt_q;
  logic        tick;

  assign tick = (tick_cnt_q == TickMax);

  always_ff @(posedge clk) begin
    if (reset || tick) begin
      tick_cnt_q <= 16'd0;
    end else begin
      tick_cnt_q <= tick_cnt_q + 16'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  logic [2:0] state_q, state_d;
  logic [3:0] s_q, s_d;
  logic [2:0] n_q, n_d;
  logic [7:0] b_q, b_d;
  logic       stop_ok;
  logic       accept;
  logic       stop_err;
`ifdef DEBUG_CMD_RX_PARITY_EN
  logic       par_err_q, par_err_d;

  assign stop_ok = rx_s && !par_err_q;
`else
  assign stop_ok = rx_s;
`endif

  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    n_d      = n_q;
    b_d      = b_q;
    accept   = 1'b0;
    stop_err = 1'b0;
`ifdef DEBUG_CMD_RX_PARITY_EN
    par_err_d = par_err_q;
`endif
    case (state_q)
      StIdle: begin
        if (!rx_s) begin
          state_d = StStart;
          s_d     = 4'd0;
        end
      end
      StStart: begin
        if (tick) begin
          if (s_q == 4'd7) begin
            // Line back high at mid-start: treat as a glitch, not an error
            if (!rx_s) begin
              state_d = StData;
              s_d     = 4'd0;
              n_d     = 3'd0;
            end else begin
              state_d = StIdle;
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      StData: begin
        if (tick) begin
          if (s_q == 4'd15) begin
            s_d = 4'd0;
            b_d = {rx_s, b_q[7:1]};
            if (n_q == 3'd7) begin
`ifdef DEBUG_CMD_RX_PARITY_EN
              state_d = StParity;
`else
              state_d = StStop;
`endif
            end else begin
              n_d = n_q + 3'd1;
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
`ifdef DEBUG_CMD_RX_PARITY_EN
      StParity: begin
        if (tick) begin
          if (s_q == 4'd15) begin
            s_d       = 4'd0;
            par_err_d = ^{b_q, rx_s};
            state_d   = StStop;
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
`endif
      StStop: begin
        if (tick) begin
          if (s_q == 4'd15) begin
            state_d = StIdle;
            s_d     = 4'd0;
            if (stop_ok) begin
              accept = 1'b1;
            end else begin
              stop_err = 1'b1;
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      s_q     <= 4'd0;
      n_q     <= 3'd0;
      b_q     <= 8'd0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
    end
  end

`ifdef DEBUG_CMD_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      par_err_q <= 1'b0;
    end else begin
      par_err_q <= par_err_d;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // ASCII hex decode of the assembled byte
  // ---------------------------------------------------------------------------
  logic       is_hex;
  logic [3:0] nibble;

  always_comb begin
    is_hex = 1'b1;
    nibble = 4'd0;
    if (b_q >= 8'h30 && b_q <= 8'h39) begin
      nibble = b_q[3:0];
    end else if ((b_q >= 8'h41 && b_q <= 8'h46) || (b_q >= 8'h61 && b_q <= 8'h66)) begin
      nibble = b_q[3:0] + 4'd9;
    end else begin
      is_hex = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Nibble FIFO
  // ---------------------------------------------------------------------------
  logic [3:0]         mem_q [Depth];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic               full_q, full_d;
  logic               empty_q, empty_d;
  logic               push;
  logic               pop;
  logic               wr_en;

  assign push  = accept && is_hex;
  assign pop   = rd_rx && !empty_q;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands
  assign wr_en = push && (!full_q || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    full_d   = full_q;
    empty_d  = empty_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (wr_en && !pop) begin
      empty_d = 1'b0;
      full_d  = (wr_ptr_d == rd_ptr_q);
    end else if (pop && !wr_en) begin
      full_d  = 1'b0;
      empty_d = (rd_ptr_d == wr_ptr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= nibble;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered status pulses
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      bad_char  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      bad_char  <= accept && !is_hex;
      frame_err <= stop_err;
      overrun   <= push && full_q && !pop;
    end
  end

  assign r_data   = empty_q ? 4'd0 : mem_q[rd_ptr_q];
  assign rx_empty = empty_q;
  assign rx_full  = full_q;

endmodule

// File: tb/tb_debug_cmd_rx.sv
// Self-checking bench for debug_cmd_rx: table of single frames plus hand-written
// back-to-back, overrun, glitch and reset-mid-frame sequences (DVSR=4, 64 clocks per bit).
module tb_debug_cmd_rx;

  localparam int unsigned DVSR    = 4;
  localparam int unsigned FIFO_AW = 2;
  localparam int          BitClks = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       rd_rx;
  logic [3:0] r_data;
  logic       rx_empty;
  logic       rx_full;
  logic       bad_char;
  logic       frame_err;
  logic       overrun;

  always #5 clk = ~clk;

  debug_cmd_rx #(
    .DVSR    (DVSR),
    .FIFO_AW (FIFO_AW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .rd_rx     (rd_rx),
    .r_data    (r_data),
    .rx_empty  (rx_empty),
    .rx_full   (rx_full),
    .bad_char  (bad_char),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   n_bad = 0;
  int   n_ferr = 0;
  int   n_ovr = 0;
  int   fall_cyc = 0;
  logic prev_empty = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  // Count cycles each pulse is high and note when the FIFO last became non-empty
  always @(negedge clk) begin
    if (bad_char)  n_bad  <= n_bad + 1;
    if (frame_err) n_ferr <= n_ferr + 1;
    if (overrun)   n_ovr  <= n_ovr + 1;
    if (prev_empty && !rx_empty) fall_cyc <= cyc;
    prev_empty <= rx_empty;
  end

  typedef struct packed {
    logic [7:0] data;
    logic       stop;
    logic       push;
    logic [3:0] nib;
    logic       bad;
    logic       ferr;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; a low stop bit is released shortly after its mid-point
  task automatic send_byte(input logic [7:0] d, input logic stop);
    rx = 1'b0;
    repeat (BitClks) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (BitClks) @(negedge clk);
    end
    rx = stop;
    if (stop) begin
      repeat (BitClks) @(negedge clk);
    end else begin
      repeat (48) @(negedge clk);
      rx = 1'b1;
      repeat (BitClks - 48) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  task automatic pop_one();
    rd_rx = 1'b1;
    @(negedge clk);
    rd_rx = 1'b0;
  endtask

  task automatic align4();
    while (cyc % 4 != 0) @(negedge clk);
  endtask

  task automatic drain_expect(input string tag, input logic [3:0] e0, input logic [3:0] e1,
                              input logic [3:0] e2, input logic [3:0] e3);
    logic [3:0] exp_q [4];
    exp_q[0] = e0;
    exp_q[1] = e1;
    exp_q[2] = e2;
    exp_q[3] = e3;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s head%0d", tag, k), r_data, exp_q[k]);
      pop_one();
    end
    check($sformatf("%s empty after drain", tag), rx_empty, 1);
  endtask

  int b0, f0, o0, t0, lat;

  initial begin
    vecs[0]  = '{data: 8'h41, stop: 1'b1, push: 1'b1, nib: 4'hA, bad: 1'b0, ferr: 1'b0};
    vecs[1]  = '{data: 8'h30, stop: 1'b1, push: 1'b1, nib: 4'h0, bad: 1'b0, ferr: 1'b0};
    vecs[2]  = '{data: 8'h66, stop: 1'b1, push: 1'b1, nib: 4'hF, bad: 1'b0, ferr: 1'b0};
    vecs[3]  = '{data: 8'h39, stop: 1'b1, push: 1'b1, nib: 4'h9, bad: 1'b0, ferr: 1'b0};
    vecs[4]  = '{data: 8'h61, stop: 1'b1, push: 1'b1, nib: 4'hA, bad: 1'b0, ferr: 1'b0};
    vecs[5]  = '{data: 8'h46, stop: 1'b1, push: 1'b1, nib: 4'hF, bad: 1'b0, ferr: 1'b0};
    vecs[6]  = '{data: 8'h47, stop: 1'b1, push: 1'b0, nib: 4'h0, bad: 1'b1, ferr: 1'b0};
    vecs[7]  = '{data: 8'h2F, stop: 1'b1, push: 1'b0, nib: 4'h0, bad: 1'b1, ferr: 1'b0};
    vecs[8]  = '{data: 8'h3A, stop: 1'b1, push: 1'b0, nib: 4'h0, bad: 1'b1, ferr: 1'b0};
    vecs[9]  = '{data: 8'h40, stop: 1'b1, push: 1'b0, nib: 4'h0, bad: 1'b1, ferr: 1'b0};
    vecs[10] = '{data: 8'h60, stop: 1'b1, push: 1'b0, nib: 4'h0, bad: 1'b1, ferr: 1'b0};
    vecs[11] = '{data: 8'h67, stop: 1'b1, push: 1'b0, nib: 4'h0, bad: 1'b1, ferr: 1'b0};
    vecs[12] = '{data: 8'h35, stop: 1'b0, push: 1'b0, nib: 4'h0, bad: 1'b0, ferr: 1'b1};

    rx    = 1'b1;
    rd_rx = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset r_data", r_data, 0);
    check("reset rx_empty", rx_empty, 1);
    check("reset rx_full", rx_full, 0);
    check("reset bad_char", bad_char, 0);
    check("reset frame_err", frame_err, 0);
    check("reset overrun", overrun, 0);

    for (int i = 0; i < 13; i++) begin
      b0 = n_bad;
      f0 = n_ferr;
      o0 = n_ovr;
      send_byte(vecs[i].data, vecs[i].stop);
      idle(BitClks);
      check($sformatf("vec%0d rx_empty", i), rx_empty, !vecs[i].push);
      check($sformatf("vec%0d r_data", i), r_data, vecs[i].nib);
      check($sformatf("vec%0d bad_char", i), n_bad - b0, vecs[i].bad);
      check($sformatf("vec%0d frame_err", i), n_ferr - f0, vecs[i].ferr);
      check($sformatf("vec%0d overrun", i), n_ovr - o0, 0);
      if (vecs[i].push) begin
        pop_one();
        check($sformatf("vec%0d empty after pop", i), rx_empty, 1);
      end
    end

    // Back-to-back fill, then overrun
    send_byte(8'h30, 1'b1);
    send_byte(8'h39, 1'b1);
    send_byte(8'h66, 1'b1);
    send_byte(8'h46, 1'b1);
    idle(BitClks);
    check("b2b rx_full", rx_full, 1);
    check("b2b head", r_data, 0);
    o0 = n_ovr;
    send_byte(8'h33, 1'b1);
    idle(BitClks);
    check("overrun pulse", n_ovr - o0, 1);
    check("overrun head kept", r_data, 0);
    check("overrun still full", rx_full, 1);
    drain_expect("b2b", 4'h0, 4'h9, 4'hF, 4'hF);

    // Measure stop-sample latency from a fixed tick phase
    align4();
    t0 = cyc;
    send_byte(8'h33, 1'b1);
    idle(BitClks);
    lat = fall_cyc - t0;
    check("push latency in range", (lat >= 600 && lat <= 625), 1);
    if (lat < 600 || lat > 625) lat = 612;
    pop_one();

    // Full FIFO: pop exactly in the stop-sample cycle, push must still land
    send_byte(8'h30, 1'b1);
    send_byte(8'h39, 1'b1);
    send_byte(8'h66, 1'b1);
    send_byte(8'h46, 1'b1);
    idle(BitClks);
    o0 = n_ovr;
    align4();
    t0 = cyc;
    fork
      send_byte(8'h33, 1'b1);
      begin
        repeat (lat - 1) @(negedge clk);
        pop_one();
      end
    join
    idle(BitClks);
    check("pop+push no overrun", n_ovr - o0, 0);
    check("pop+push still full", rx_full, 1);
    drain_expect("pop+push", 4'h9, 4'hF, 4'hF, 4'h3);

    // 20-clock low glitch
    b0 = n_bad;
    f0 = n_ferr;
    rx = 1'b0;
    repeat (20) @(negedge clk);
    idle(2 * BitClks);
    check("glitch frame_err", n_ferr - f0, 0);
    check("glitch bad_char", n_bad - b0, 0);
    check("glitch rx_empty", rx_empty, 1);
    send_byte(8'h35, 1'b1);
    idle(BitClks);
    check("after glitch r_data", r_data, 5);
    pop_one();

    // Reset during bit 4 of '7' with an entry already queued
    send_byte(8'h63, 1'b1);
    idle(BitClks);
    check("pre-reset r_data", r_data, 4'hC);
    b0 = n_bad;
    f0 = n_ferr;
    o0 = n_ovr;
    rx = 1'b0;
    repeat (BitClks) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = logic'((8'h37 >> i) & 8'h01);
      repeat (BitClks) @(negedge clk);
    end
    rx = 1'b1;
    repeat (20) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("midreset r_data", r_data, 0);
    check("midreset rx_empty", rx_empty, 1);
    check("midreset rx_full", rx_full, 0);
    reset = 1'b0;
    idle(4 * BitClks);
    check("midreset no pulses", (n_bad - b0) + (n_ferr - f0) + (n_ovr - o0), 0);
    check("midreset still empty", rx_empty, 1);
    send_byte(8'h37, 1'b1);
    idle(BitClks);
    check("after reset rx_empty", rx_empty, 0);
    check("after reset r_data", r_data, 7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

endmodule
